cond_flag_unit: RTL and testbench

- Consumer end of the ALU condition-code interface.
- Holds the architectural status flags {N,Z,C,V}, which it latches from the ALU C/N/V/Z outputs when an instruction requests a flag update.
- Returns the stored carry to the ALU Cin for ADDC/SUBNC/ISUBNC.
- Evaluates 4-bit instruction condition fields under a valid/ready handshake, and sequences a pipeline flush when a conditional branch is taken.

---
 rtl/cond_flag_unit.sv | 139 +++++++++++++
 tb/tb_cond_flag_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// Condition-code consumer: holds {N,Z,C,V}, feeds stored carry back to the ALU,
// evaluates condition fields under valid/ready and sequences a flush on taken branches.
module cond_flag_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          BYPASS       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       s_bit,
    input  logic       flags_wr,
    input  logic [3:0] flags_wdata,
    input  logic       eval_valid,
    input  logic [3:0] eval_cond,
    input  logic       eval_branch,
    output logic       eval_ready,
    output logic       pass_valid,
    output logic       pass,
    output logic       flush,
    output logic       cin,
    output logic [3:0] flags
);

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] flags_eff;
    logic       eval_ready_q;
    logic       pass_valid_q;
    logic       pass_q;
    logic       flush_q;
    logic       cond_met;
    logic       accept;
    logic       f_n, f_z, f_c, f_v;

    // Direct status-register writes take priority over ALU-driven updates.
    always_comb begin
        flags_d = flags_q;
        if (flags_wr) begin
            flags_d = flags_wdata;
        end else if (s_bit) begin
            flags_d = {alu_n, alu_z, alu_c, alu_v};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_eff = BYPASS ? flags_d : flags_q;
    assign {f_n, f_z, f_c, f_v} = flags_eff;

    always_comb begin
        cond_met = 1'b0;
        case (eval_cond)
            4'b0000: cond_met = f_z;
            4'b0001: cond_met = ~f_z;
            4'b0010: cond_met = f_c;
            4'b0011: cond_met = ~f_c;
            4'b0100: cond_met = f_n;
            4'b0101: cond_met = ~f_n;
            4'b0110: cond_met = f_v;
            4'b0111: cond_met = ~f_v;
            4'b1000: cond_met = f_c & ~f_z;
            4'b1001: cond_met = ~f_c | f_z;
            4'b1010: cond_met = (f_n == f_v);
            4'b1011: cond_met = (f_n != f_v);
            4'b1100: cond_met = ~f_z & (f_n == f_v);
            4'b1101: cond_met = f_z | (f_n != f_v);
            4'b1110: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    assign accept = eval_valid & eval_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            eval_ready_q <= 1'b1;
            pass_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            pass_valid_q <= accept;
            if (accept) begin
                pass_q <= cond_met;
            end
            case (state_q)
                StIdle: begin
                    if (accept && cond_met && eval_branch) begin
                        state_q      <= StFlush;
                        cnt_q        <= FlushLoad;
                        flush_q      <= 1'b1;
                        eval_ready_q <= 1'b0;
                    end
                end
                StFlush: begin
                    // Counter holds the number of flush cycles still to run, this one included.
                    if (cnt_q <= 4'd1) begin
                        state_q      <= StIdle;
                        cnt_q        <= 4'd0;
                        flush_q      <= 1'b0;
                        eval_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    cnt_q        <= 4'd0;
                    flush_q      <= 1'b0;
                    eval_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign eval_ready = eval_ready_q;
    assign pass_valid = pass_valid_q;
    assign pass       = pass_q;
    assign flush      = flush_q;
    assign flags      = flags_q;
    assign cin        = flags_q[1];

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: two instances (bypass/2-cycle flush and registered/4-cycle flush)
// share stimulus and are checked against a behavioural model of the flag and flush rules.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       s_bit, flags_wr;
    logic [3:0] flags_wdata;
    logic       eval_valid;
    logic [3:0] eval_cond;
    logic       eval_branch;

    logic       a_eval_ready, a_pass_valid, a_pass, a_flush, a_cin;
    logic [3:0] a_flags;
    logic       b_eval_ready, b_pass_valid, b_pass, b_flush, b_cin;
    logic [3:0] b_flags;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0] m_flags;
    int         m_left [2];
    logic       m_pv   [2];
    logic       m_pass [2];

    always #5 clk = ~clk;

    cond_flag_unit #(.FLUSH_CYCLES(2), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .s_bit(s_bit), .flags_wr(flags_wr), .flags_wdata(flags_wdata),
        .eval_valid(eval_valid), .eval_cond(eval_cond), .eval_branch(eval_branch),
        .eval_ready(a_eval_ready), .pass_valid(a_pass_valid), .pass(a_pass),
        .flush(a_flush), .cin(a_cin), .flags(a_flags)
    );

    cond_flag_unit #(.FLUSH_CYCLES(4), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .s_bit(s_bit), .flags_wr(flags_wr), .flags_wdata(flags_wdata),
        .eval_valid(eval_valid), .eval_cond(eval_cond), .eval_branch(eval_branch),
        .eval_ready(b_eval_ready), .pass_valid(b_pass_valid), .pass(b_pass),
        .flush(b_flush), .cin(b_cin), .flags(b_flags)
    );

    // Even codes select a base test, odd codes negate it.
    function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] cond);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    task automatic clear_inputs();
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        s_bit = 0; flags_wr = 0; flags_wdata = 4'b0000;
        eval_valid = 0; eval_cond = 4'b0000; eval_branch = 0;
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_pv[k] = 1'b0; m_pass[k] = 1'b0;
        end
    endtask

    // Advance one clock edge, updating the model from the inputs present before the edge.
    task automatic cycle();
        logic [3:0] nxt, eff;
        logic res, acc;
        nxt = flags_wr ? flags_wdata : (s_bit ? {alu_n, alu_z, alu_c, alu_v} : m_flags);
        for (int k = 0; k < 2; k++) begin
            eff = (k == 0) ? nxt : m_flags;
            res = cond_ref(eff, eval_cond);
            acc = eval_valid && (m_left[k] == 0);
            m_pv[k] = acc;
            if (acc) m_pass[k] = res;
            if (m_left[k] > 0) m_left[k]--;
            if (acc && res && eval_branch) m_left[k] = (k == 0) ? 2 : 4;
        end
        m_flags = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] val);
        clear_inputs();
        flags_wr = 1; flags_wdata = val;
        cycle();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_vec++;
        if ({a_flags, a_cin, a_eval_ready, a_flush, a_pass_valid, a_pass} !== 9'b0000_0_1_0_0_0) begin
            n_err++;
            $display("FAIL reset_a: got flags=%b cin=%b rdy=%b flush=%b pv=%b pass=%b",
                     a_flags, a_cin, a_eval_ready, a_flush, a_pass_valid, a_pass);
        end
        n_vec++;
        if ({b_flags, b_cin, b_eval_ready, b_flush, b_pass_valid, b_pass} !== 9'b0000_0_1_0_0_0) begin
            n_err++;
            $display("FAIL reset_b: got flags=%b cin=%b rdy=%b flush=%b pv=%b pass=%b",
                     b_flags, b_cin, b_eval_ready, b_flush, b_pass_valid, b_pass);
        end
        rst_n = 1;
        eval_valid = 1; eval_cond = 4'b0000;
        cycle();
        n_vec++;
        if ({a_pass_valid, a_pass} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_eq_eval: got pv=%b pass=%b, want pv=1 pass=0", a_pass_valid, a_pass);
        end
        clear_inputs();
        cycle();
        n_vec++;
        if (a_pass_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pv_one_shot: got pv=%b, want 0", a_pass_valid);
        end
    endtask

    task automatic test_flag_latch();
        clear_inputs();
        s_bit = 1; {alu_n, alu_z, alu_c, alu_v} = 4'b0010;
        cycle();
        clear_inputs();
        n_vec++;
        if ({a_flags, a_cin} !== 5'b0010_1) begin
            n_err++;
            $display("FAIL flag_latch: got flags=%b cin=%b, want 0010/1", a_flags, a_cin);
        end
        eval_valid = 1; eval_cond = 4'b1000;
        cycle();
        n_vec++;
        if (a_pass !== 1'b1) begin
            n_err++;
            $display("FAIL cond_hi: got pass=%b, want 1", a_pass);
        end
        eval_cond = 4'b1001;
        cycle();
        clear_inputs();
        n_vec++;
        if (a_pass !== 1'b0) begin
            n_err++;
            $display("FAIL cond_ls: got pass=%b, want 0", a_pass);
        end
    endtask

    task automatic test_bypass();
        set_flags(4'b0000);
        s_bit = 1; alu_z = 1;
        eval_valid = 1; eval_cond = 4'b0000;
        cycle();
        clear_inputs();
        n_vec++;
        if (a_pass !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_on: got pass=%b, want 1", a_pass);
        end
        n_vec++;
        if ({b_pass, b_flags} !== 5'b0_0100) begin
            n_err++;
            $display("FAIL bypass_off: got pass=%b flags=%b, want 0/0100", b_pass, b_flags);
        end
    endtask

    task automatic test_write_priority();
        clear_inputs();
        flags_wr = 1; flags_wdata = 4'b1001;
        s_bit = 1; {alu_n, alu_z, alu_c, alu_v} = 4'b0110;
        cycle();
        clear_inputs();
        n_vec++;
        if ({a_flags, b_flags, a_cin} !== 9'b1001_1001_0) begin
            n_err++;
            $display("FAIL wr_priority: got a=%b b=%b cin=%b, want 1001/1001/0",
                     a_flags, b_flags, a_cin);
        end
        eval_valid = 1; eval_cond = 4'b1010;
        cycle();
        n_vec++;
        if (a_pass !== 1'b1) begin
            n_err++;
            $display("FAIL cond_ge: got pass=%b, want 1", a_pass);
        end
        eval_cond = 4'b1111;
        cycle();
        clear_inputs();
        n_vec++;
        if (a_pass !== 1'b0) begin
            n_err++;
            $display("FAIL cond_nv: got pass=%b, want 0", a_pass);
        end
    endtask

    task automatic test_flush();
        set_flags(4'b0100);
        eval_valid = 1; eval_branch = 1; eval_cond = 4'b0000;
        cycle();
        // Keep a non-branch request pending through the flush.
        eval_branch = 0;
        n_vec++;
        if ({a_pass_valid, a_pass, a_flush, a_eval_ready} !== 4'b1110) begin
            n_err++;
            $display("FAIL flush_c1: got pv=%b pass=%b flush=%b rdy=%b, want 1110",
                     a_pass_valid, a_pass, a_flush, a_eval_ready);
        end
        cycle();
        n_vec++;
        if ({a_pass_valid, a_flush, a_eval_ready} !== 3'b010) begin
            n_err++;
            $display("FAIL flush_c2: got pv=%b flush=%b rdy=%b, want 010",
                     a_pass_valid, a_flush, a_eval_ready);
        end
        cycle();
        n_vec++;
        if ({a_pass_valid, a_flush, a_eval_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL flush_end: got pv=%b flush=%b rdy=%b, want 001",
                     a_pass_valid, a_flush, a_eval_ready);
        end
        cycle();
        clear_inputs();
        n_vec++;
        if ({a_pass_valid, a_pass, a_flush} !== 3'b110) begin
            n_err++;
            $display("FAIL held_accept: got pv=%b pass=%b flush=%b, want 110",
                     a_pass_valid, a_pass, a_flush);
        end
        n_vec++;
        if (b_flush !== 1'b1) begin
            n_err++;
            $display("FAIL flush4_c4: got flush=%b, want 1", b_flush);
        end
        for (int i = 0; i < 4; i++) cycle();
        n_vec++;
        if ({b_flush, b_eval_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush4_end: got flush=%b rdy=%b, want 01", b_flush, b_eval_ready);
        end
    endtask

    task automatic test_not_taken();
        set_flags(4'b0100);
        eval_valid = 1; eval_branch = 1; eval_cond = 4'b0001;
        cycle();
        clear_inputs();
        n_vec++;
        if ({a_pass_valid, a_pass, a_flush, b_flush} !== 4'b1000) begin
            n_err++;
            $display("FAIL not_taken: got pv=%b pass=%b flush_a=%b flush_b=%b, want 1000",
                     a_pass_valid, a_pass, a_flush, b_flush);
        end
        cycle();
        n_vec++;
        if ({a_flush, b_flush, a_eval_ready, b_eval_ready} !== 4'b0011) begin
            n_err++;
            $display("FAIL not_taken_after: got flush=%b%b rdy=%b%b, want 0011",
                     a_flush, b_flush, a_eval_ready, b_eval_ready);
        end
    endtask

    task automatic test_back_to_back();
        set_flags(4'b0110);
        for (int i = 0; i < 16; i++) begin
            eval_valid = 1; eval_branch = 0; eval_cond = 4'(i);
            cycle();
            n_vec++;
            if ({a_pass_valid, a_pass} !== {1'b1, m_pass[0]}) begin
                n_err++;
                $display("FAIL b2b_cond%0d: got pv=%b pass=%b, want 1/%b",
                         i, a_pass_valid, a_pass, m_pass[0]);
            end
        end
        clear_inputs();
        cycle();
    endtask

    task automatic test_reset_mid_flush();
        set_flags(4'b0100);
        eval_valid = 1; eval_branch = 1; eval_cond = 4'b0000;
        cycle();
        clear_inputs();
        cycle();
        n_vec++;
        if (b_flush !== 1'b1) begin
            n_err++;
            $display("FAIL mid_flush_pre: got flush=%b, want 1", b_flush);
        end
        #2 rst_n = 0;
        #1;
        n_vec++;
        if ({b_flush, b_eval_ready, b_flags} !== 6'b01_0000) begin
            n_err++;
            $display("FAIL mid_flush_reset: got flush=%b rdy=%b flags=%b, want 0/1/0000",
                     b_flush, b_eval_ready, b_flags);
        end
        model_reset();
        #1 rst_n = 1;
        cycle();
        n_vec++;
        if ({b_flush, b_eval_ready, a_flush} !== 3'b010) begin
            n_err++;
            $display("FAIL mid_flush_after: got flush_b=%b rdy_b=%b flush_a=%b, want 010",
                     b_flush, b_eval_ready, a_flush);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
            s_bit       = ($urandom_range(0, 2) == 0);
            flags_wr    = ($urandom_range(0, 5) == 0);
            flags_wdata = 4'($urandom);
            eval_valid  = ($urandom_range(0, 9) < 7);
            eval_cond   = 4'($urandom);
            eval_branch = ($urandom_range(0, 9) < 3);
            cycle();
            exp_v = {m_pv[0], m_pass[0], m_left[0] != 0, m_left[0] == 0, m_flags[1], m_flags};
            n_vec++;
            if ({a_pass_valid, a_pass, a_flush, a_eval_ready, a_cin, a_flags} !== exp_v) begin
                n_err++;
                $display("FAIL rand_a[%0d]: got %b, want %b", i,
                         {a_pass_valid, a_pass, a_flush, a_eval_ready, a_cin, a_flags}, exp_v);
            end
            exp_v = {m_pv[1], m_pass[1], m_left[1] != 0, m_left[1] == 0, m_flags[1], m_flags};
            n_vec++;
            if ({b_pass_valid, b_pass, b_flush, b_eval_ready, b_cin, b_flags} !== exp_v) begin
                n_err++;
                $display("FAIL rand_b[%0d]: got %b, want %b", i,
                         {b_pass_valid, b_pass, b_flush, b_eval_ready, b_cin, b_flags}, exp_v);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_flag_latch();
        test_bypass();
        test_write_priority();
        test_flush();
        test_not_taken();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
